// File: rtl/fir_filter_mac.sv
// fir_filter_mac: serial FIR filter built around one shared multiplier-accumulator.
// Each accepted sample is convolved with a runtime-writable coefficient RAM.
// The result is rounded half-up, shifted and saturated, then presented with a
// one-cycle out_valid strobe. History taps that were never written since the
// last reset or flush contribute zero.
module fir_filter_mac #(
  parameter int DATA_W = 20,
  parameter int COEF_W = 20,
  parameter int TAPS   = 128,
  parameter int SHIFT  = 16,
  parameter int OUT_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + AW;
  localparam int PW    = DATA_W + COEF_W;
  localparam int CW    = $clog2(TAPS + 3);
  localparam int FW    = AW + 1;

  // Rounding constant (half an output LSB) and saturation bounds at accumulator+1 width.
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(SHIFT > 0 ? 1 : 0) << (SHIFT > 0 ? SHIFT - 1 : 0);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a shifted accumulator value into the signed output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] c;
    if (v > MAXV) begin
      c = MAXV;
    end else if (v < MINV) begin
      c = MINV;
    end else begin
      c = v;
    end
    return c[OUT_W-1:0];
  endfunction

  state_t                   state_r, state_s;
  logic [CW-1:0]            cnt_r;
  logic [AW-1:0]            wptr_r, rptr_r;
  logic [FW-1:0]            fill_r;
  logic                     rd_v_r, rd_use_r, mul_v_r;
  logic signed [COEF_W-1:0] coef_q_r;
  logic signed [DATA_W-1:0] data_q_r;
  logic signed [PW-1:0]     prod_r, prod_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W:0]    ext_s, sum_s, shr_s;
  logic                     in_ready_r, out_valid_r;
  logic signed [OUT_W-1:0]  out_data_r;
  logic                     accept_s, coef_wr_s, issue_s, use_s;

  logic signed [COEF_W-1:0] coef_mem [TAPS];
  logic signed [DATA_W-1:0] delay_mem [TAPS];

  assign accept_s  = in_valid && in_ready_r && !flush;
  assign coef_wr_s = coef_we && in_ready_r && (32'(coef_addr) < 32'(TAPS));
  assign issue_s   = (state_r == MAC) && (32'(cnt_r) < 32'(TAPS));
  assign use_s     = 32'(cnt_r) < 32'(fill_r);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Next-state logic: flush wins, MAC runs until the last product is accumulated.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = accept_s ? MAC : IDLE;
        MAC:     state_s = (32'(cnt_r) == 32'(TAPS + 2)) ? DONE : MAC;
        DONE:    state_s = accept_s ? MAC : IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Gated product and round/shift of the final accumulator.
  always_comb begin
    prod_s = '0;
    if (rd_use_r) begin
      prod_s = coef_q_r * data_q_r;
    end else begin
      prod_s = '0;
    end
    ext_s = {acc_r[ACC_W-1], acc_r};
    sum_s = ext_s + RND;
    shr_s = sum_s >>> SHIFT;
  end

  // Coefficient and delay-line RAMs with registered reads; contents are not reset.
  always_ff @(posedge clk) begin
    if (coef_wr_s) coef_mem[coef_addr] <= coef_wdata;
    if (accept_s) delay_mem[wptr_r] <= in_data;
    coef_q_r <= coef_mem[cnt_r[AW-1:0]];
    data_q_r <= delay_mem[rptr_r];
  end

  // Control, pipeline valids, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      wptr_r      <= '0;
      rptr_r      <= '0;
      fill_r      <= '0;
      rd_v_r      <= 1'b0;
      rd_use_r    <= 1'b0;
      mul_v_r     <= 1'b0;
      prod_r      <= '0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != MAC);
      out_valid_r <= (state_s == DONE);
      rd_v_r      <= issue_s && !flush;
      rd_use_r    <= issue_s && use_s && !flush;
      mul_v_r     <= rd_v_r && !flush;
      prod_r      <= prod_s;
      if (flush) begin
        wptr_r <= '0;
        fill_r <= '0;
        cnt_r  <= '0;
      end else if (accept_s) begin
        wptr_r <= (wptr_r == AW'(TAPS - 1)) ? '0 : wptr_r + AW'(1);
        fill_r <= (fill_r == FW'(TAPS)) ? fill_r : fill_r + FW'(1);
        rptr_r <= wptr_r;
        cnt_r  <= '0;
        acc_r  <= '0;
      end else if (state_r == MAC) begin
        cnt_r <= cnt_r + CW'(1);
        if (issue_s) rptr_r <= (rptr_r == '0) ? AW'(TAPS - 1) : rptr_r - AW'(1);
        if (mul_v_r) acc_r <= acc_r + {{AW{prod_r[PW-1]}}, prod_r};
      end
      if (state_s == DONE) out_data_r <= sat_out(shr_s);
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac: three instances cover the impulse/zero-fill/
// handshake/flush/reset cases (TAPS=8, SHIFT=0), saturation (TAPS=8, SHIFT=16)
// and rounding (TAPS=2, SHIFT=16). Expected values are hand-computed constants.
module tb_fir_filter_mac;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic signed [19:0] in_data    [3];
  logic               in_valid   [3];
  logic               in_ready   [3];
  logic               flush      [3];
  logic               coef_we    [3];
  logic [2:0]         coef_addr  [3];
  logic signed [19:0] coef_wdata [3];
  logic signed [19:0] out_data   [3];
  logic               out_valid  [3];

  int n_checks = 0;
  int n_fail   = 0;

  fir_filter_mac #(.DATA_W(20), .COEF_W(20), .TAPS(8), .SHIFT(0), .OUT_W(20)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .coef_we(coef_we[0]),
    .coef_addr(coef_addr[0]), .coef_wdata(coef_wdata[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]));

  fir_filter_mac #(.DATA_W(20), .COEF_W(20), .TAPS(8), .SHIFT(16), .OUT_W(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .flush(flush[1]), .coef_we(coef_we[1]),
    .coef_addr(coef_addr[1]), .coef_wdata(coef_wdata[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]));

  fir_filter_mac #(.DATA_W(20), .COEF_W(20), .TAPS(2), .SHIFT(16), .OUT_W(20)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .flush(flush[2]), .coef_we(coef_we[2]),
    .coef_addr(coef_addr[2][0:0]), .coef_wdata(coef_wdata[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]));

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 2) ? 6 : 12;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input int d, input int k, input int v);
    coef_we[d]    = 1'b1;
    coef_addr[d]  = k[2:0];
    coef_wdata[d] = v[19:0];
    step();
    coef_we[d] = 1'b0;
  endtask

  task automatic do_flush(input int d);
    flush[d] = 1'b1;
    step();
    flush[d] = 1'b0;
  endtask

  task automatic accept(input int d, input int x, input bit we, input int k, input int v);
    int g;
    g = 0;
    while (!in_ready[d] && g < 50) begin
      step();
      g++;
    end
    check_eq("ready_wait", in_ready[d], 1);
    in_data[d]    = x[19:0];
    in_valid[d]   = 1'b1;
    coef_we[d]    = we;
    coef_addr[d]  = k[2:0];
    coef_wdata[d] = v[19:0];
    step();
    in_valid[d] = 1'b0;
    coef_we[d]  = 1'b0;
  endtask

  // n counts the cycles after the accept edge; n=1 is the first one.
  task automatic wait_out(input int d, output int n);
    n = 1;
    while (!out_valid[d] && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic send_w(input int d, input int x, input bit we, input int k, input int v,
                        input longint exp, input bit chk, input string tag);
    int n;
    accept(d, x, we, k, v);
    wait_out(d, n);
    check_eq({tag, "_latency"}, n, lat(d));
    if (chk) check_eq(tag, out_data[d], exp);
  endtask

  task automatic send(input int d, input int x, input longint exp, input bit chk, input string tag);
    send_w(d, x, 1'b0, 0, 0, exp, chk, tag);
  endtask

  int imp_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
  int ones_exp[9] = '{106, 107, 108, 109, 110, 111, 12, 8, 8};
  int rnd_in  [4] = '{32768, 32767, -32768, -32769};
  int rnd_exp [4] = '{1, 0, 0, -1};

  initial begin
    int n, acc_cnt, first_i, last_i, seen;
    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0; in_valid[d] = 1'b0; flush[d] = 1'b0;
      coef_we[d] = 1'b0; coef_addr[d] = '0; coef_wdata[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check_eq("reset_in_ready", in_ready[0], 1);
    check_eq("reset_out_valid", out_valid[0], 0);
    check_eq("reset_out_data", out_data[0], 0);

    // Impulse response.
    for (int k = 0; k < 8; k++) set_coef(0, k, k + 1);
    for (int i = 0; i < 9; i++) send(0, (i == 0) ? 1 : 0, imp_exp[i], 1'b1, "impulse");

    // Zero-fill of unwritten history.
    do_flush(0);
    for (int k = 0; k < 8; k++) set_coef(0, k, 1);
    send(0, 100, 100, 1'b1, "zfill_first");
    send(0, 5, 105, 1'b1, "zfill_second");
    for (int i = 0; i < 9; i++) send(0, 1, ones_exp[i], 1'b1, "zfill_ones");

    // Coefficient lock: write during MAC ignored, idle write and accept-cycle write applied.
    do_flush(0);
    accept(0, 10, 1'b0, 0, 0);
    set_coef(0, 0, 7);
    wait_out(0, n);
    check_eq("lock_out_seen", out_valid[0], 1);
    check_eq("lock_mac_write_ignored", out_data[0], 10);
    set_coef(0, 0, 3);
    send(0, 2, 16, 1'b1, "lock_idle_write");
    send_w(0, 1, 1'b1, 1, 5, 23, 1'b1, "lock_accept_write");

    // Handshake: in_valid held high, accepts spaced by TAPS+4.
    acc_cnt = 0; first_i = -1; last_i = -1;
    in_data[0] = '0;
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = 1'b1;
      if (in_ready[0]) begin
        acc_cnt++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      step();
    end
    in_valid[0] = 1'b0;
    check_eq("hs_accept_count", acc_cnt, 2);
    check_eq("hs_accept_spacing", last_i - first_i, 12);
    repeat (15) step();
    check_eq("hs_idle_ready", in_ready[0], 1);

    // Flush mid-MAC.
    for (int k = 0; k < 8; k++) set_coef(0, k, k + 1);
    do_flush(0);
    accept(0, 1, 1'b0, 0, 0);
    step();
    step();
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    check_eq("flush_ready_next", in_ready[0], 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0]) seen++;
      step();
    end
    check_eq("flush_no_out_valid", seen, 0);
    for (int i = 0; i < 3; i++) send(0, (i == 0) ? 1 : 0, imp_exp[i], 1'b1, "flush_impulse");

    // Saturation.
    for (int k = 0; k < 8; k++) set_coef(1, k, 65535);
    for (int i = 0; i < 8; i++) send(1, 524287, 524287, i == 7, "sat_pos");
    for (int i = 0; i < 8; i++) send(1, -524288, -524288, i == 7, "sat_neg");

    // Rounding half up.
    set_coef(2, 0, 1);
    set_coef(2, 1, 0);
    for (int i = 0; i < 4; i++) send(2, rnd_in[i], rnd_exp[i], 1'b1, "round");

    // Asynchronous reset mid-MAC.
    accept(0, 1, 1'b0, 0, 0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid[0], 0);
    check_eq("rst_out_data", out_data[0], 0);
    check_eq("rst_in_ready", in_ready[0], 1);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid[0]) seen++;
    end
    check_eq("rst_no_out_valid", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
